int_div_32: RTL and testbench

INT_DIV_32 -- requirements
Module: int_div_32

---
 rtl/int_div_32.sv | 128 ++++++++++++
 tb/tb_int_div_32.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int_div_32.sv
// Iterative 32-bit integer divider: restoring radix-2, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU with the usual divide-by-zero and signed-overflow results.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one restoring step per cycle, 32 steps
// FIX   | apply recorded signs, load result
// DONE  | result valid, waiting for consumer
module int_div_32 #(
  parameter int OPERAND_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [1:0]              op_i,
  input  logic [OPERAND_SIZE-1:0] X_i,
  input  logic [OPERAND_SIZE-1:0] Y_i,
  input  logic                    kill_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [OPERAND_SIZE-1:0] Result_o
);

  localparam int W = OPERAND_SIZE;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state_q;
  logic [W-1:0]   divisor_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   quo_q;
  logic [W-1:0]   result_q;
  logic           is_rem_q;
  logic           q_neg_q;
  logic           r_neg_q;
  logic [4:0]     cnt_q;

  logic           is_signed;
  logic           x_neg;
  logic           y_neg;
  logic [W-1:0]   x_abs;
  logic [W-1:0]   y_abs;
  logic           div_zero;
  logic           ovf;

  logic [W:0]     rem_sh;
  logic [W-1:0]   diff;
  logic           step_ok;
  logic [W-1:0]   quo_fix;
  logic [W-1:0]   rem_fix;

  assign is_signed = ~op_i[0];
  assign x_neg     = is_signed & X_i[W-1];
  assign y_neg     = is_signed & Y_i[W-1];
  assign x_abs     = x_neg ? -X_i : X_i;
  assign y_abs     = y_neg ? -Y_i : Y_i;
  assign div_zero  = (Y_i == '0);
  assign ovf       = is_signed & (X_i == {1'b1, {(W-1){1'b0}}}) & (&Y_i);

  // The 33-bit trial is non-negative when the shifted-out bit is set or the low
  // bits already cover the divisor; the low W bits of the difference are exact then.
  assign rem_sh  = {rem_q, quo_q[W-1]};
  assign step_ok = rem_sh[W] | (rem_sh[W-1:0] >= divisor_q);
  assign diff    = rem_sh[W-1:0] - divisor_q;

  assign quo_fix = q_neg_q ? -quo_q : quo_q;
  assign rem_fix = r_neg_q ? -rem_q : rem_q;

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign Result_o = result_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      cnt_q     <= '0;
    end else if (kill_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            is_rem_q <= op_i[1];
            cnt_q    <= '0;
            if (div_zero) begin
              result_q <= op_i[1] ? X_i : '1;
              state_q  <= DONE;
            end else if (ovf) begin
              result_q <= op_i[1] ? '0 : {1'b1, {(W-1){1'b0}}};
              state_q  <= DONE;
            end else begin
              divisor_q <= y_abs;
              rem_q     <= '0;
              quo_q     <= x_abs;
              q_neg_q   <= x_neg ^ y_neg;
              r_neg_q   <= x_neg;
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_ok ? diff : rem_sh[W-1:0];
          quo_q <= {quo_q[W-2:0], step_ok};
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= FIX;
        end
        FIX: begin
          result_q <= is_rem_q ? rem_fix : quo_fix;
          state_q  <= DONE;
        end
        DONE: begin
          if (ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_div_32.sv
// Bench for int_div_32: directed corner cases, kill/reset behaviour and a random
// sweep checked against a plain-arithmetic reference model.
module tb_int_div_32;

  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] X_i = '0;
  logic [31:0] Y_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] Result_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  int_div_32 #(.OPERAND_SIZE(32)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .X_i      (X_i),
    .Y_i      (Y_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .Result_o (Result_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] x,
                                            input logic [31:0] y);
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    if (y == 32'd0) return op[1] ? x : 32'hFFFF_FFFF;
    if (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return op[1] ? 32'h0 : 32'h8000_0000;
    if (op[0]) return op[1] ? (x % y) : (x / y);
    return op[1] ? 32'(sx % sy) : 32'(sx / sy);
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] x,
                                    input logic [31:0] y);
    return (y == 32'd0) || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
  endfunction

  // One full transaction; latency is counted in rising edges after the accept edge
  // (special cases are already valid right after the accept edge).
  task automatic run_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int hold, input bit handoff,
                        input string tag);
    int          lat;
    int          exp_lat;
    logic [31:0] held;
    bit          stable;
    exp_lat = is_special(op, x, y) ? 0 : 33;
    @(negedge clk_i);
    check_eq({tag, "/ready_idle"}, {31'b0, ready_o}, 32'd1);
    op_i = op; X_i = x; Y_i = y; valid_i = 1'b1; ready_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    X_i = $urandom;
    Y_i = $urandom;
    lat = 0;
    while (!valid_o && lat < 80) begin
      @(negedge clk_i);
      lat++;
    end
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/result"}, Result_o, exp);
    held = Result_o;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      if (!valid_o || Result_o !== held) stable = 1'b0;
    end
    check_eq({tag, "/hold_stable"}, {31'b0, stable}, 32'd1);
    ready_i = 1'b1;
    if (handoff) begin
      op_i = OP_DIVU; X_i = 32'd9; Y_i = 32'd3; valid_i = 1'b1;
    end
    @(negedge clk_i);
    ready_i = 1'b0;
    check_eq({tag, "/valid_drop"}, {31'b0, valid_o}, 32'd0);
    check_eq({tag, "/ready_back"}, {31'b0, ready_o}, 32'd1);
    valid_i = 1'b0;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    bit          saw;

    #1;
    check_eq("reset/ready", {31'b0, ready_o}, 32'd1);
    check_eq("reset/valid", {31'b0, valid_o}, 32'd0);
    check_eq("reset/result", Result_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 0, 0, "divu_100_7");
    run_op(OP_REMU, 32'd100, 32'd7, 32'h0000_0002, 1, 0, "remu_100_7");
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0, 0, "div_m7_2");
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0, "rem_m7_2");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0, 0, "divu_max_1");
    run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0, "divu_5_0");
    run_op(OP_REM, 32'd5, 32'd0, 32'h0000_0005, 0, 0, "rem_5_0");
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0, "div_ovf");
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0, "rem_ovf");
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 5, 1, "backpressure");

    // kill beats a pending accept in IDLE
    @(negedge clk_i);
    op_i = OP_DIVU; X_i = 32'd50; Y_i = 32'd5; valid_i = 1'b1; kill_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0; kill_i = 1'b0;
    check_eq("kill_vs_accept/ready", {31'b0, ready_o}, 32'd1);

    // kill after 10 CALC steps
    @(negedge clk_i);
    op_i = OP_DIVU; X_i = 32'd1000; Y_i = 32'd7; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (10) @(negedge clk_i);
    kill_i = 1'b1;
    @(negedge clk_i);
    kill_i = 1'b0;
    check_eq("kill_calc/ready", {31'b0, ready_o}, 32'd1);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk_i);
      if (valid_o) saw = 1'b1;
    end
    check_eq("kill_calc/no_valid", {31'b0, saw}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 0, 0, "after_kill");

    // asynchronous reset in the middle of CALC
    @(negedge clk_i);
    op_i = OP_DIVU; X_i = 32'hFFFF_FFFF; Y_i = 32'd3; valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("async_rst/ready", {31'b0, ready_o}, 32'd1);
    check_eq("async_rst/valid", {31'b0, valid_o}, 32'd0);
    check_eq("async_rst/result", Result_o, 32'd0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, 32'h0000_000E, 0, 0, "post_reset");

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = $urandom_range(1, 15);
        3: x = $urandom_range(0, 1000);
        4: y = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(op, x, y, ref_model(op, x, y), $urandom_range(0, 3), 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
